// File: rtl/dispatch1_4.sv
// 1-to-4 steering block: one valid/ready input routed by in_sel into four one-entry output slots.
// Optional per-channel accept counters are compiled in with DISPATCH1_4_STATS_EN.
module dispatch1_4 #(
    parameter int unsigned WIDTH = 32
`ifdef DISPATCH1_4_STATS_EN
   ,parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
`ifdef DISPATCH1_4_STATS_EN
   ,input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic             w_acc;
    logic [3:0]       w_load;
    logic [3:0]       w_drn;

    // A full slot only blocks the input when its own consumer is stalled.
    assign in_ready = !r_valid[in_sel] | out_ready[in_sel];
    assign w_acc    = in_valid & in_ready;
    assign w_load   = w_acc ? 4'(4'b0001 << in_sel) : 4'b0000;
    assign w_drn    = r_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            // Load wins over drain so a slot can refill in the cycle it empties.
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (w_drn[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign busy      = |r_valid;

`ifdef DISPATCH1_4_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Saturating accept counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || stats_clr) begin
                r_cnt[k] <= '0;
            end else if (w_load[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule
